// File: rtl/fast_clk_pkg.sv
// Shared types and constants for the forwarded DDR clock generator.
// Loopback checking is enabled by FAST_CLOCK_OUTPUT_LOOPBACK_EN.
package fast_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DIV_W_DEF   = 8;
  localparam int HALF_BYPASS = 0;

endpackage

// File: rtl/fco_sync2.sv
// Two-flop synchronizer for the returned clock.
// Only instantiated when FAST_CLOCK_OUTPUT_LOOPBACK_EN is defined.
module fco_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fast_clock_output.sv
// Programmable forwarded clock as ODDR2 rise/fall data, glitch-free.
// Optional loopback check: define FAST_CLOCK_OUTPUT_LOOPBACK_EN.
module fast_clock_output
  import fast_clk_pkg::*;
#(
  parameter int DIV_W          = DIV_W_DEF,
  parameter int DEFAULT_HALF   = 2,
  parameter int SETTLE_PERIODS = 16
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_half,
  input  logic             cfg_valid,
  output logic             cfg_ready,
`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
  input  logic             clk_fb,
`endif
  output logic             ddr_d0,
  output logic             ddr_d1,
  output logic             clk_running,
  output logic             fb_valid
);

  localparam int PW = $clog2(SETTLE_PERIODS + 1);

  state_t           state_q, state_d;
  logic             level_q, level_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] stg_q, stg_d;
  logic             staged_q, staged_d;
  logic [PW-1:0]    per_q, per_d;
  logic             d0_d, d1_d;
  logic             xfer, bypass, bnd;
  logic [DIV_W-1:0] n_idle;

  function automatic logic [DIV_W-1:0] load_of(
    input logic [DIV_W-1:0] n
  );
    return (n == '0) ? '0 : n - DIV_W'(1);
  endfunction

  assign cfg_ready = !staged_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign bypass    = (half_q == DIV_W'(HALF_BYPASS));
  // Last cycle of a low phase, or every cycle at full rate.
  assign bnd       = bypass || (!level_q && cnt_q == '0);
  assign n_idle    = xfer     ? cfg_half :
                     staged_q ? stg_q    : half_q;

  assign clk_running = (state_q == ST_RUN) &&
                       (per_q == PW'(SETTLE_PERIODS));

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    stg_d    = stg_q;
    staged_d = staged_q;
    per_d    = per_q;
    d0_d     = 1'b0;
    d1_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer || staged_q) begin
          half_d   = n_idle;
          staged_d = 1'b0;
          per_d    = '0;
        end
        if (en) begin
          state_d = ST_RUN;
          level_d = 1'b1;
          cnt_d   = load_of(n_idle);
          per_d   = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        d0_d = bypass | level_q;
        d1_d = !bypass & level_q;
        if (xfer) begin
          staged_d = 1'b1;
          stg_d    = cfg_half;
        end
        if (bnd && staged_q) begin
          half_d   = stg_q;
          staged_d = 1'b0;
          level_d  = 1'b1;
          cnt_d    = load_of(stg_q);
          per_d    = '0;
        end else begin
          if (bnd && per_q != PW'(SETTLE_PERIODS))
            per_d = per_q + PW'(1);
          if (!bypass) begin
            if (cnt_q == '0) begin
              level_d = !level_q;
              cnt_d   = load_of(half_q);
            end else begin
              cnt_d = cnt_q - DIV_W'(1);
            end
          end
        end
        if (state_q == ST_RUN) begin
          if (!en)
            state_d = ST_DRAIN;
        end else if (en) begin
          state_d = ST_RUN;
        end else if (bnd) begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      half_q   <= DIV_W'(DEFAULT_HALF);
      stg_q    <= '0;
      staged_q <= 1'b0;
      per_q    <= '0;
      ddr_d0   <= 1'b0;
      ddr_d1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      stg_q    <= stg_d;
      staged_q <= staged_d;
      per_q    <= per_d;
      ddr_d0   <= d0_d;
      ddr_d1   <= d1_d;
    end
  end

`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
  logic       fb_s;
  logic [7:0] hist_q;
  logic       mix_hi, mix_lo, slow;

  fco_sync2 u_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (clk_fb),
    .q   (fb_s)
  );

  always_ff @(posedge sys_clk) begin
    if (rst)
      hist_q <= '0;
    else
      hist_q <= {hist_q[6:0], fb_s};
  end

  assign mix_hi = hist_q[7:5] != 3'b000 &&
                  hist_q[7:5] != 3'b111;
  assign mix_lo = hist_q[2:0] != 3'b000 &&
                  hist_q[2:0] != 3'b111;
  // Windowed check only resolves short periods.
  assign slow   = half_q == '0 || half_q > DIV_W'(3);
  assign fb_valid = clk_running &&
                    (slow ? (hist_q != 8'h00 && hist_q != 8'hFF)
                          : (mix_hi && mix_lo));
`else
  assign fb_valid = clk_running;
`endif

endmodule

// File: tb/tb_fast_clock_output.sv
// Self-checking bench for fast_clock_output against a
// period-position reference model.
module tb_fast_clock_output;

  localparam int DIV_W  = 8;
  localparam int DEF_N  = 2;
  localparam int SETTLE = 16;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [DIV_W-1:0] cfg_half = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             ddr_d0, ddr_d1;
  logic             clk_running, fb_valid;
`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
  logic             fb_tie = 1'b0;
  logic             clk_fb;
  assign clk_fb = fb_tie & ddr_d0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  fast_clock_output #(
    .DIV_W          (DIV_W),
    .DEFAULT_HALF   (DEF_N),
    .SETTLE_PERIODS (SETTLE)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .en          (en),
    .cfg_half    (cfg_half),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
    .clk_fb      (clk_fb),
`endif
    .ddr_d0      (ddr_d0),
    .ddr_d1      (ddr_d1),
    .clk_running (clk_running),
    .fb_valid    (fb_valid)
  );

  // Reference: position within the current period, 0..2N-1.
  bit m_act, m_drain, m_pend, m_took;
  int m_n = DEF_N;
  int m_pv, m_pos, m_per;
  bit e_d0, e_d1;

  function automatic logic [4:0] exp_vec();
    bit r;
    r = m_act && !m_drain && m_per == SETTLE;
    return {e_d0, e_d1, !m_pend, r, r};
  endfunction

  function automatic logic [4:0] obs();
`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
    return {ddr_d0, ddr_d1, cfg_ready,
            clk_running, clk_running};
`else
    return {ddr_d0, ddr_d1, cfg_ready,
            clk_running, fb_valid};
`endif
  endfunction

  task automatic tick();
    bit xfer, bnd, apply;
    @(posedge sys_clk);
    m_took = 1'b0;
    xfer = cfg_valid && !m_pend;
    if (rst) begin
      m_act = 0; m_drain = 0; m_pend = 0;
      m_n = DEF_N; m_pos = 0; m_per = 0;
      e_d0 = 0; e_d1 = 0;
    end else if (!m_act) begin
      e_d0 = 0; e_d1 = 0;
      if (m_pend) begin
        m_n = m_pv; m_pend = 0;
      end
      if (xfer) begin
        m_n = cfg_half; m_took = 1;
      end
      if (en) begin
        m_act = 1; m_drain = 0;
        m_pos = 0; m_per = 0;
      end
    end else begin
      e_d0 = (m_n == 0) ? 1'b1 : (m_pos < m_n);
      e_d1 = (m_n == 0) ? 1'b0 : (m_pos < m_n);
      bnd = (m_n == 0) || (m_pos == 2 * m_n - 1);
      apply = bnd && m_pend;
      if (apply) begin
        m_n = m_pv; m_pend = 0;
        m_pos = 0; m_per = 0;
      end else begin
        if (bnd && m_per < SETTLE) m_per++;
        m_pos = bnd ? 0 : m_pos + 1;
      end
      if (xfer) begin
        m_pend = 1; m_pv = cfg_half; m_took = 1;
      end
      if (m_drain && !en && bnd) m_act = 0;
      else m_drain = !en;
    end
    #1;
    if (m_took) cfg_valid = 1'b0;
  endtask

  task automatic go_idle();
    int k;
    en = 1'b0;
    k = 0;
    while (m_act && k < 40) begin
      tick(); k++;
    end
    tick();
    if (m_act) begin
      n_chk++; n_fail++;
      $display("FAIL go_idle timeout");
    end
  endtask

  task automatic cfg_idle(input int v);
    cfg_valid = 1'b1;
    cfg_half = DIV_W'(v);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    tick(); tick();
    n_chk++;
    if (obs() !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset got %b want 00100", obs());
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (obs() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle got %b want %b",
               obs(), exp_vec());
    end
  endtask

  task automatic test_default_rate();
    logic [7:0] pat;
    int rise;
    pat = '0; rise = -1;
    en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL default k=%0d got %b want %b",
                 k, obs(), exp_vec());
      end
      if (k >= 2 && k <= 9) pat[9-k] = ddr_d0 & ddr_d1;
      if (rise < 0 && clk_running) rise = k;
    end
    n_chk++;
    if (pat !== 8'b11001100) begin
      n_fail++;
      $display("FAIL default_pat got %b want 11001100", pat);
    end
    n_chk++;
    if (rise != 65) begin
      n_fail++;
      $display("FAIL default_settle got %0d want 65", rise);
    end
    go_idle();
  endtask

  task automatic test_bypass();
    int rise, bad;
    rise = -1; bad = 0;
    cfg_valid = 1'b1; cfg_half = '0; en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bypass k=%0d got %b want %b",
                 k, obs(), exp_vec());
      end
      if (k >= 2 && {ddr_d0, ddr_d1} !== 2'b10) bad++;
      if (rise < 0 && clk_running) rise = k;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bypass_pat got %0d bad want 0", bad);
    end
    n_chk++;
    if (rise != 17) begin
      n_fail++;
      $display("FAIL bypass_settle got %0d want 17", rise);
    end
    go_idle();
  endtask

  task automatic test_rate_change();
    int k, rdy_lo, run_lo;
    rdy_lo = 0; run_lo = 0;
    cfg_idle(3);
    en = 1'b1;
    for (int i = 0; i < 120; i++) tick();
    k = 0;
    while (m_pos != 1 && k < 20) begin
      tick(); k++;
    end
    cfg_valid = 1'b1; cfg_half = 8'd1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rate i=%0d got %b want %b",
                 i, obs(), exp_vec());
      end
      if (!cfg_ready) rdy_lo++;
      if (!clk_running) run_lo++;
    end
    n_chk++;
    if (rdy_lo != 4) begin
      n_fail++;
      $display("FAIL rate_ready_low got %0d want 4", rdy_lo);
    end
    n_chk++;
    if (run_lo != 32) begin
      n_fail++;
      $display("FAIL rate_resettle got %0d want 32", run_lo);
    end
    go_idle();
  endtask

  task automatic test_drain();
    int k, ones;
    ones = 0;
    cfg_idle(4);
    en = 1'b1;
    for (int i = 0; i < 140; i++) tick();
    k = 0;
    while (m_pos != 1 && k < 20) begin
      tick(); k++;
    end
    en = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain i=%0d got %b want %b",
                 i, obs(), exp_vec());
      end
      if (i == 1) begin
        n_chk++;
        if (clk_running !== 1'b0) begin
          n_fail++;
          $display("FAIL drain_drop got %b want 0",
                   clk_running);
        end
      end
      if (ddr_d0) ones++;
    end
    n_chk++;
    if (ones != 3) begin
      n_fail++;
      $display("FAIL drain_high got %0d want 3", ones);
    end
    tick();
  endtask

  task automatic test_drain_cancel();
    en = 1'b1;
    for (int i = 0; i < 140; i++) tick();
    en = 1'b0;
    tick();
    n_chk++;
    if (clk_running !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_drop got %b want 0", clk_running);
    end
    en = 1'b1;
    tick();
    n_chk++;
    if (clk_running !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel_rearm got %b want 1", clk_running);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL cancel i=%0d got %b want %b",
                 i, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midrun();
    int k;
    k = 0;
    while (!ddr_d0 && k < 20) begin
      tick(); k++;
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if ({ddr_d0, ddr_d1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid got %b%b want 00",
               ddr_d0, ddr_d1);
    end
    rst = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if (!cfg_valid && $urandom_range(49) == 0) begin
        cfg_valid = 1'b1;
        cfg_half = DIV_W'($urandom_range(5));
      end
      if ($urandom_range(39) == 0) en = !en;
      rst = ($urandom_range(699) == 0);
      tick();
      n_chk++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random i=%0d got %b want %b",
                 i, obs(), exp_vec());
      end
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    go_idle();
  endtask

`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
  task automatic test_loopback();
    go_idle();
    cfg_idle(2);
    en = 1'b1; fb_tie = 1'b1;
    for (int i = 0; i < 80; i++) tick();
    n_chk++;
    if (fb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fb_good got %b want 1", fb_valid);
    end
    fb_tie = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    n_chk++;
    if (fb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fb_stuck got %b want 0", fb_valid);
    end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_default_rate();
    test_bypass();
    test_rate_change();
    test_drain();
    test_drain_cancel();
    test_reset_midrun();
    test_random();
`ifdef FAST_CLOCK_OUTPUT_LOOPBACK_EN
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
